// File: rtl/gshare_br_predictor_if.sv
// Fetch/writeback bundle between the core and the gshare predictor.
// The core drives the master side; the predictor is the slave.
interface gshare_br_predictor_if #(
    parameter int unsigned HIST_BITS = 4,
    parameter int unsigned CNT_W     = 16
);
    logic [15:0]          if_pc;
    logic                 prediction_taken;
    logic [HIST_BITS-1:0] pred_ghr;
    logic                 ready;
    logic                 wb_isbranch;
    logic [15:0]          wb_pcplus2;
    logic [HIST_BITS-1:0] wb_ghr;
    logic                 wb_pred_taken;
    logic                 wb_actual_taken;
    logic [CNT_W-1:0]     branch_count;
    logic [CNT_W-1:0]     mispredict_count;

    modport master (
        output if_pc, wb_isbranch, wb_pcplus2, wb_ghr,
        output wb_pred_taken, wb_actual_taken,
        input  prediction_taken, pred_ghr, ready,
        input  branch_count, mispredict_count
    );

    modport slave (
        input  if_pc, wb_isbranch, wb_pcplus2, wb_ghr,
        input  wb_pred_taken, wb_actual_taken,
        output prediction_taken, pred_ghr, ready,
        output branch_count, mispredict_count
    );
endinterface

// File: rtl/gshare_br_predictor.sv
// Global-history predictor with a table of 2-bit saturating counters.
// Define GSHARE_XOR_EN for the XOR-folded index; default is {pc,ghr}.
module gshare_br_predictor #(
    parameter int unsigned PC_BITS    = 4,
    parameter int unsigned HIST_BITS  = 4,
    parameter logic [1:0]  INIT_STATE = 2'b01,
    parameter int unsigned CNT_W      = 16
) (
    input logic clk,
    input logic rst_n,
    gshare_br_predictor_if.slave bp
);
`ifdef GSHARE_XOR_EN
    localparam int unsigned IDX_W = PC_BITS;
`else
    localparam int unsigned IDX_W = PC_BITS + HIST_BITS;
`endif
    localparam int unsigned DEPTH = 1 << IDX_W;

    typedef enum logic {S_INIT, S_RUN} state_e;

    function automatic logic [IDX_W-1:0] hash(
        input logic [PC_BITS-1:0]   p,
        input logic [HIST_BITS-1:0] h
    );
`ifdef GSHARE_XOR_EN
        logic [PC_BITS+HIST_BITS-1:0] hz;
        hz = {{PC_BITS{1'b0}}, h};
        return p ^ hz[PC_BITS-1:0];
`else
        return {p, h};
`endif
    endfunction

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     init_idx_q, init_idx_d;
    logic [HIST_BITS-1:0] ghr_q, ghr_d;
    logic                 ready_q, ready_d;
    logic [CNT_W-1:0]     br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0]     mis_cnt_q, mis_cnt_d;
    logic [1:0]           tbl_q [DEPTH];

    logic                 tbl_we;
    logic [IDX_W-1:0]     tbl_widx;
    logic [1:0]           tbl_wdata;
    logic [IDX_W-1:0]     ridx;
    logic [IDX_W-1:0]     widx;
    logic [15:0]          wb_pc;
    logic [1:0]           cur;
    logic [HIST_BITS:0]   ghr_sh;
    logic                 unused;

    assign ridx = hash(bp.if_pc[PC_BITS:1], ghr_q);
    assign bp.prediction_taken = (state_q == S_RUN) & tbl_q[ridx][1];
    assign bp.pred_ghr         = ghr_q;
    assign bp.ready            = ready_q;
    assign bp.branch_count     = br_cnt_q;
    assign bp.mispredict_count = mis_cnt_q;

    // Only the index bits of the PCs matter; the rest is deliberately dropped.
    assign unused = ^{bp.if_pc[15:PC_BITS+1], bp.if_pc[0],
                      wb_pc[15:PC_BITS+1], wb_pc[0], ghr_sh[HIST_BITS]};

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        ghr_d      = ghr_q;
        ready_d    = ready_q;
        br_cnt_d   = br_cnt_q;
        mis_cnt_d  = mis_cnt_q;
        tbl_we     = 1'b0;
        tbl_widx   = init_idx_q;
        tbl_wdata  = INIT_STATE;
        wb_pc      = bp.wb_pcplus2 - 16'd2;
        widx       = hash(wb_pc[PC_BITS:1], bp.wb_ghr);
        cur        = tbl_q[widx];
        ghr_sh     = {ghr_q, bp.wb_actual_taken};
        unique case (state_q)
            S_INIT: begin
                tbl_we     = 1'b1;
                init_idx_d = init_idx_q + 1'b1;
                if (&init_idx_q) begin
                    state_d = S_RUN;
                    ready_d = 1'b1;
                end
            end
            S_RUN: begin
                if (bp.wb_isbranch) begin
                    tbl_we   = 1'b1;
                    tbl_widx = widx;
                    if (bp.wb_actual_taken)
                        tbl_wdata = (cur == 2'b11) ? cur : cur + 2'd1;
                    else
                        tbl_wdata = (cur == 2'b00) ? cur : cur - 2'd1;
                    ghr_d = ghr_sh[HIST_BITS-1:0];
                    if (br_cnt_q != '1)
                        br_cnt_d = br_cnt_q + 1'b1;
                    if ((bp.wb_pred_taken != bp.wb_actual_taken)
                        && (mis_cnt_q != '1))
                        mis_cnt_d = mis_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_INIT;
            init_idx_q <= '0;
            ghr_q      <= '0;
            ready_q    <= 1'b0;
            br_cnt_q   <= '0;
            mis_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            ghr_q      <= ghr_d;
            ready_q    <= ready_d;
            br_cnt_q   <= br_cnt_d;
            mis_cnt_q  <= mis_cnt_d;
        end
    end

    // Table has no reset; the INIT sweep gives it defined contents.
    always_ff @(posedge clk) begin
        if (tbl_we)
            tbl_q[tbl_widx] <= tbl_wdata;
    end
endmodule

// File: tb/tb_gshare_br_predictor.sv
// Randomised bench for gshare_br_predictor against a table/GHR model.
// Also instantiates a CNT_W=2 copy to exercise counter saturation.
module tb_gshare_br_predictor;
    localparam int TB_PC = 4;
    localparam int TB_H  = 4;
`ifdef GSHARE_XOR_EN
    localparam int TB_IDX = TB_PC;
`else
    localparam int TB_IDX = TB_PC + TB_H;
`endif
    localparam int DEPTH = 1 << TB_IDX;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    int mt [DEPTH];
    int mghr, mbr, mmis;

    gshare_br_predictor_if #(.HIST_BITS(4), .CNT_W(16)) bus ();
    gshare_br_predictor_if #(.HIST_BITS(4), .CNT_W(2))  bus2 ();

    assign bus2.if_pc           = bus.if_pc;
    assign bus2.wb_isbranch     = bus.wb_isbranch;
    assign bus2.wb_pcplus2      = bus.wb_pcplus2;
    assign bus2.wb_ghr          = bus.wb_ghr;
    assign bus2.wb_pred_taken   = bus.wb_pred_taken;
    assign bus2.wb_actual_taken = bus.wb_actual_taken;

    gshare_br_predictor #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bp(bus)
    );
    gshare_br_predictor #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bp(bus2)
    );

    always #5 clk = ~clk;

    function automatic int midx(input logic [15:0] pc, input int h);
        int p;
        p = int'(pc >> 1) % (1 << TB_PC);
`ifdef GSHARE_XOR_EN
        return p ^ (h % (1 << TB_PC));
`else
        return p * (1 << TB_H) + h;
`endif
    endfunction

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic mpred(input logic [15:0] pc);
        return mt[midx(pc, mghr)] >= 2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mt[i] = 1;
        mghr = 0;
        mbr = 0;
        mmis = 0;
    endtask

    task automatic model_update(input logic [15:0] pp2, input int g,
                                input logic pt, input logic at);
        logic [15:0] wpc;
        int i;
        wpc = pp2 - 16'd2;
        i = midx(wpc, g);
        if (at) mt[i] = (mt[i] == 3) ? 3 : mt[i] + 1;
        else    mt[i] = (mt[i] == 0) ? 0 : mt[i] - 1;
        mghr = ((mghr << 1) | int'(at)) % (1 << TB_H);
        mbr++;
        if (pt != at) mmis++;
    endtask

    task automatic wb_update(input logic [15:0] pp2, input int g,
                             input logic pt, input logic at);
        bus.wb_isbranch = 1'b1;
        bus.wb_pcplus2 = pp2;
        bus.wb_ghr = 4'(g);
        bus.wb_pred_taken = pt;
        bus.wb_actual_taken = at;
        @(posedge clk);
        #1;
        model_update(pp2, g, pt, at);
        bus.wb_isbranch = 1'b0;
    endtask

    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (bus.ready !== 1'b1 && cycles < 2 * DEPTH + 8) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic test_reset();
        logic exp_r;
        rst_n = 1'b0;
        bus.if_pc = 16'h0006;
        bus.wb_isbranch = 1'b1;
        bus.wb_pcplus2 = 16'h0008;
        bus.wb_ghr = 4'h0;
        bus.wb_pred_taken = 1'b0;
        bus.wb_actual_taken = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got %0b want 0", bus.ready);
        end
        n_checks++;
        if (bus.prediction_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pred: got %0b want 0", bus.prediction_taken);
        end
        n_checks++;
        if (bus.pred_ghr !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_ghr: got %0h want 0", bus.pred_ghr);
        end
        n_checks++;
        if (bus.branch_count !== 16'd0 || bus.mispredict_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_counts: got %0d/%0d want 0/0",
                     bus.branch_count, bus.mispredict_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= DEPTH; k++) begin
            @(posedge clk);
            #1;
            exp_r = (k == DEPTH);
            n_checks++;
            if (bus.ready !== exp_r) begin
                n_fail++;
                $display("FAIL init_ready cyc %0d: got %0b want %0b",
                         k, bus.ready, exp_r);
            end
            if (k < DEPTH) begin
                n_checks++;
                if (bus.prediction_taken !== 1'b0) begin
                    n_fail++;
                    $display("FAIL init_pred cyc %0d: got %0b want 0",
                             k, bus.prediction_taken);
                end
            end
        end
        bus.wb_isbranch = 1'b0;
        n_checks++;
        if (bus.branch_count !== 16'd0 || bus.pred_ghr !== 4'h0) begin
            n_fail++;
            $display("FAIL init_ignores_wb: got cnt %0d ghr %0h want 0 0",
                     bus.branch_count, bus.pred_ghr);
        end
        model_reset();
    endtask

    task automatic test_basic();
        bus.if_pc = 16'h0006;
        #1;
        n_checks++;
        if (bus.prediction_taken !== mpred(16'h0006) || bus.pred_ghr !== 4'h0) begin
            n_fail++;
            $display("FAIL basic_first: got %0b/%0h want %0b/0",
                     bus.prediction_taken, bus.pred_ghr, mpred(16'h0006));
        end
        wb_update(16'h0008, 0, 1'b0, 1'b1);
        wb_update(16'h0008, 0, 1'b0, 1'b1);
        n_checks++;
        if (bus.pred_ghr !== 4'(mghr) || mghr != 3) begin
            n_fail++;
            $display("FAIL basic_ghr: got %0h want 3", bus.pred_ghr);
        end
        n_checks++;
        if (bus.prediction_taken !== mpred(16'h0006)) begin
            n_fail++;
            $display("FAIL basic_other_idx: got %0b want %0b",
                     bus.prediction_taken, mpred(16'h0006));
        end
        for (int i = 0; i < 4; i++) wb_update(16'h0010, 0, 1'b0, 1'b0);
        n_checks++;
        if (bus.prediction_taken !== 1'b1 || mpred(16'h0006) !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_trained: got %0b want 1", bus.prediction_taken);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) wb_update(16'h0022, 15, 1'b1, 1'b1);
        bus.if_pc = 16'h0020;
        #1;
        n_checks++;
        if (bus.prediction_taken !== 1'b1 || mt[midx(16'h0020, 15)] != 3) begin
            n_fail++;
            $display("FAIL sat_high: got %0b want 1", bus.prediction_taken);
        end
        wb_update(16'h0022, 15, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) wb_update(16'h000C, 0, 1'b1, 1'b1);
        n_checks++;
        if (bus.prediction_taken !== mpred(16'h0020) || mpred(16'h0020) !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_after_nt: got %0b want 1", bus.prediction_taken);
        end
    endtask

    task automatic test_hazard();
        logic exp_old, exp_new;
        bus.if_pc = 16'h0012;
        bus.wb_isbranch = 1'b1;
        bus.wb_pcplus2 = 16'h0014;
        bus.wb_ghr = 4'hF;
        bus.wb_pred_taken = 1'b0;
        bus.wb_actual_taken = 1'b1;
        #1;
        exp_old = mpred(16'h0012);
        n_checks++;
        if (bus.prediction_taken !== exp_old || mghr != 15) begin
            n_fail++;
            $display("FAIL hazard_old: got %0b want %0b", bus.prediction_taken, exp_old);
        end
        @(posedge clk);
        #1;
        model_update(16'h0014, 15, 1'b0, 1'b1);
        bus.wb_isbranch = 1'b0;
        exp_new = mpred(16'h0012);
        n_checks++;
        if (bus.prediction_taken !== exp_new || exp_new === exp_old) begin
            n_fail++;
            $display("FAIL hazard_new: got %0b want %0b", bus.prediction_taken, exp_new);
        end
    endtask

    task automatic test_stats();
        int cyc;
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (DEPTH / 2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        n_checks++;
        if (bus.ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midinit_ready: got %0b want 0", bus.ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(cyc);
        n_checks++;
        if (cyc != DEPTH) begin
            n_fail++;
            $display("FAIL init_restart_len: got %0d want %0d", cyc, DEPTH);
        end
        model_reset();
        for (int i = 0; i < 10; i++)
            wb_update(16'(2 * i + 2), i % 16, 1'b1, (i % 3 == 1) ? 1'b0 : 1'b1);
        n_checks++;
        if (bus.branch_count !== 16'd10 || bus.mispredict_count !== 16'd3) begin
            n_fail++;
            $display("FAIL stats16: got %0d/%0d want 10/3",
                     bus.branch_count, bus.mispredict_count);
        end
        n_checks++;
        if (bus2.branch_count !== 2'd3 || bus2.mispredict_count !== 2'd3) begin
            n_fail++;
            $display("FAIL stats2_sat: got %0d/%0d want 3/3",
                     bus2.branch_count, bus2.mispredict_count);
        end
    endtask

    task automatic test_random();
        logic br;
        for (int n = 0; n < 400; n++) begin
            br = ($urandom_range(0, 2) != 0);
            bus.if_pc = 16'($urandom) & 16'h003E;
            bus.wb_isbranch = br;
            bus.wb_pcplus2 = ($urandom_range(0, 9) == 0) ? 16'h0000
                           : (($urandom_range(0, 1) == 0) ? bus.if_pc + 16'd2
                                                          : 16'($urandom));
            bus.wb_ghr = ($urandom_range(0, 1) == 0) ? 4'(mghr) : 4'($urandom);
            bus.wb_pred_taken = 1'($urandom);
            bus.wb_actual_taken = ($urandom_range(0, 3) != 0);
            #1;
            n_checks++;
            if (bus.prediction_taken !== mpred(bus.if_pc)
                || bus.pred_ghr !== 4'(mghr)) begin
                n_fail++;
                $display("FAIL rnd_pred %0d pc %0h: got %0b/%0h want %0b/%0h",
                         n, bus.if_pc, bus.prediction_taken, bus.pred_ghr,
                         mpred(bus.if_pc), mghr);
            end
            @(posedge clk);
            #1;
            if (br)
                model_update(bus.wb_pcplus2, int'(bus.wb_ghr),
                             bus.wb_pred_taken, bus.wb_actual_taken);
            n_checks++;
            if (bus.branch_count !== 16'(sat(mbr, 16))
                || bus.mispredict_count !== 16'(sat(mmis, 16))
                || bus2.branch_count !== 2'(sat(mbr, 2))
                || bus2.mispredict_count !== 2'(sat(mmis, 2))) begin
                n_fail++;
                $display("FAIL rnd_stats %0d: got %0d/%0d %0d/%0d want %0d/%0d",
                         n, bus.branch_count, bus.mispredict_count,
                         bus2.branch_count, bus2.mispredict_count, mbr, mmis);
            end
        end
        bus.wb_isbranch = 1'b0;
    endtask

    initial begin
        bus.if_pc = '0;
        bus.wb_isbranch = 1'b0;
        bus.wb_pcplus2 = '0;
        bus.wb_ghr = '0;
        bus.wb_pred_taken = 1'b0;
        bus.wb_actual_taken = 1'b0;
        test_reset();
        test_basic();
        test_saturation();
        test_hazard();
        test_stats();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
